// File: rtl/countdown_timer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// countdown_timer
//
// Down-counting mm:ss timer. The value is preset with the active-low up/down
// buttons while the global mode bus selects the seconds or minutes field.
// A falling edge on btn_start toggles run/pause. When the count reaches 00:00
// the timer enters ALARM. It leaves ALARM after ALARM_SECS ticks, or earlier
// if btn_start acknowledges it.
//
// Optional feature (macro COUNTDOWN_AUTO_RELOAD_EN):
//   A 12-bit preset register captures {min,sec} on every IDLE->RUN transition.
//   When ALARM exits, that preset is reloaded into min/sec.
//   btn_clr also zeros the preset.
//
// Ports:
//   clk_1Hz    in   1 Hz tick, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_up     in   active-low, level; increments the selected field
//   btn_down   in   active-low, level; decrements the selected field
//   btn_start  in   active-low; falling edge toggles run/pause / acknowledges
//   btn_clr    in   active-low, level; clears the timer
//   mode       in   [2:0] global mode bus
//   min        out  [5:0] remaining minutes
//   sec        out  [5:0] remaining seconds
//   running    out  high while in RUN
//   alarm      out  high while in ALARM
//   state      out  [1:0] IDLE=0, RUN=1, PAUSE=2, ALARM=3
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter logic [2:0] SET_SEC_MODE = 3'b101,
    parameter logic [2:0] SET_MIN_MODE = 3'b110,
    parameter int         MAX_MIN      = 59,
    parameter int         ALARM_SECS   = 10
) (
    input  logic       clk_1Hz,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic [2:0] mode,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [5:0] MIN_TOP    = 6'(MAX_MIN);
    localparam logic [5:0] SEC_TOP    = 6'd59;
    localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECS - 1);

    state_t     state_reg, state_next;
    logic [5:0] min_reg, min_next;
    logic [5:0] sec_reg, sec_next;
    logic [5:0] alarm_cnt_reg, alarm_cnt_next;
    logic       btn_start_q;
    logic       running_reg, running_next;
    logic       alarm_reg, alarm_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [11:0] preset_reg, preset_next;
`endif

    logic       start_ev;
    logic       is_zero;
    logic [5:0] adj_min, adj_sec;
    logic [5:0] dec_min, dec_sec;

    assign start_ev = btn_start_q & ~btn_start;
    assign is_zero  = (min_reg == 6'd0) && (sec_reg == 6'd0);

    // Field adjustment for the set modes. btn_up wins when both are low.
    // Wraps stay inside the field: no carry or borrow into minutes.
    always_comb begin
        adj_min = min_reg;
        adj_sec = sec_reg;
        if (mode == SET_SEC_MODE) begin
            if (!btn_up) begin
                adj_sec = (sec_reg >= SEC_TOP) ? 6'd0 : sec_reg + 6'd1;
            end else if (!btn_down) begin
                adj_sec = (sec_reg == 6'd0) ? SEC_TOP : sec_reg - 6'd1;
            end
        end else if (mode == SET_MIN_MODE) begin
            if (!btn_up) begin
                adj_min = (min_reg >= MIN_TOP) ? 6'd0 : min_reg + 6'd1;
            end else if (!btn_down) begin
                adj_min = (min_reg == 6'd0) ? MIN_TOP : min_reg - 6'd1;
            end
        end
    end

    // One-second decrement with borrow from minutes. RUN is never entered at
    // 00:00, so the minutes field never underflows here.
    always_comb begin
        if (sec_reg != 6'd0) begin
            dec_min = min_reg;
            dec_sec = sec_reg - 6'd1;
        end else begin
            dec_min = min_reg - 6'd1;
            dec_sec = SEC_TOP;
        end
    end

    // Next-state and next-value logic.
    // Priority on each edge: clear, then start edge, then set/decrement.
    always_comb begin
        state_next     = state_reg;
        min_next       = min_reg;
        sec_next       = sec_reg;
        alarm_cnt_next = alarm_cnt_reg;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        preset_next    = preset_reg;
`endif
        if (!btn_clr) begin
            state_next     = IDLE;
            min_next       = 6'd0;
            sec_next       = 6'd0;
            alarm_cnt_next = 6'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            preset_next    = 12'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_ev) begin
                        if (!is_zero) begin
                            state_next = RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            preset_next = {min_reg, sec_reg};
`endif
                        end
                    end else begin
                        min_next = adj_min;
                        sec_next = adj_sec;
                    end
                end
                RUN: begin
                    if (start_ev) begin
                        state_next = PAUSE;
                    end else begin
                        min_next = dec_min;
                        sec_next = dec_sec;
                        // Alarm rises on the same edge that shows 00:00.
                        if ((dec_min == 6'd0) && (dec_sec == 6'd0)) begin
                            state_next     = ALARM;
                            alarm_cnt_next = 6'd0;
                        end
                    end
                end
                PAUSE: begin
                    if (start_ev) begin
                        state_next = is_zero ? IDLE : RUN;
                    end else begin
                        min_next = adj_min;
                        sec_next = adj_sec;
                    end
                end
                ALARM: begin
                    // The entry edge counts as tick 0, so alarm stays high
                    // for ALARM_SECS ticks unless it is acknowledged.
                    if (start_ev || (alarm_cnt_reg >= ALARM_LAST)) begin
                        state_next     = IDLE;
                        alarm_cnt_next = 6'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        min_next       = preset_reg[11:6];
                        sec_next       = preset_reg[5:0];
`endif
                    end else begin
                        alarm_cnt_next = alarm_cnt_reg + 6'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // The flags are registered from the next state, so they change on the
    // same edge as state.
    assign running_next = (state_next == RUN);
    assign alarm_next   = (state_next == ALARM);

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            min_reg       <= 6'd0;
            sec_reg       <= 6'd0;
            alarm_cnt_reg <= 6'd0;
            btn_start_q   <= 1'b1;
            running_reg   <= 1'b0;
            alarm_reg     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            preset_reg    <= 12'd0;
`endif
        end else begin
            state_reg     <= state_next;
            min_reg       <= min_next;
            sec_reg       <= sec_next;
            alarm_cnt_reg <= alarm_cnt_next;
            btn_start_q   <= btn_start;
            running_reg   <= running_next;
            alarm_reg     <= alarm_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            preset_reg    <= preset_next;
`endif
        end
    end

    assign min     = min_reg;
    assign sec     = sec_reg;
    assign state   = state_reg;
    assign running = running_reg;
    assign alarm   = alarm_reg;

endmodule

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed testbench for countdown_timer.
// Stimulus drives inputs on the falling clock edge. At the same time it
// queues the expected {min,sec,state} for the next rising edge.
// A separate monitor samples the outputs 1 ns after every rising edge, and
// also after an asynchronous reset assertion. It pops the oldest queued
// expectation and compares it with the outputs.
// running and alarm are checked as functions of the expected state.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam logic [2:0] OFF  = 3'b000;
    localparam logic [2:0] SSEC = 3'b101;
    localparam logic [2:0] SMIN = 3'b110;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam logic [5:0] RELOAD_A = 6'd2;
    localparam logic [5:0] RELOAD_C = 6'd3;
`else
    localparam logic [5:0] RELOAD_A = 6'd0;
    localparam logic [5:0] RELOAD_C = 6'd0;
`endif

    logic       clk_1Hz;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_start;
    logic       btn_clr;
    logic [2:0] mode;
    logic [5:0] min;
    logic [5:0] sec;
    logic       running;
    logic       alarm;
    logic [1:0] state;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          n_checks;
    int          n_fail;

    countdown_timer dut (
        .clk_1Hz  (clk_1Hz),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_start(btn_start),
        .btn_clr  (btn_clr),
        .mode     (mode),
        .min      (min),
        .sec      (sec),
        .running  (running),
        .alarm    (alarm),
        .state    (state)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    task automatic push_exp(input string name, input logic [5:0] em,
                            input logic [5:0] es, input logic [1:0] est);
        exp_q.push_back({em, es, est});
        name_q.push_back(name);
    endtask

    // Drive one tick of inputs and queue the expected result of that tick.
    task automatic step(input string name, input logic up, input logic dn,
                        input logic st, input logic clr, input logic [2:0] md,
                        input logic [5:0] em, input logic [5:0] es,
                        input logic [1:0] est);
        @(negedge clk_1Hz);
        btn_up    = up;
        btn_down  = dn;
        btn_start = st;
        btn_clr   = clr;
        mode      = md;
        push_exp(name, em, es, est);
    endtask

    // Monitor: compares outputs against the scoreboard.
    initial begin
        logic [13:0] e;
        logic [15:0] act, want;
        string       n;
        forever begin
            @(posedge clk_1Hz or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                n    = name_q.pop_front();
                act  = {min, sec, state, running, alarm};
                want = {e, (e[1:0] == 2'd1), (e[1:0] == 2'd3)};
                n_checks++;
                if (act !== want) begin
                    n_fail++;
                    $display("FAIL %s: got min=%0d sec=%0d state=%0d running=%b alarm=%b, expected min=%0d sec=%0d state=%0d running=%b alarm=%b",
                             n, min, sec, state, running, alarm,
                             want[15:10], want[9:4], want[3:2], want[1], want[0]);
                end else begin
                    $display("check %s ok: min=%0d sec=%0d state=%0d running=%b alarm=%b",
                             n, min, sec, state, running, alarm);
                end
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        btn_up    = 1'b1;
        btn_down  = 1'b1;
        btn_start = 1'b1;
        btn_clr   = 1'b1;
        mode      = OFF;

        // Power-on reset.
        #2;
        push_exp("reset", 6'd0, 6'd0, 2'd0);
        rst_n = 1'b0;
        @(negedge clk_1Hz);
        @(negedge clk_1Hz);
        #2;
        rst_n = 1'b1;

        // Seconds set, with a held button repeating each tick.
        step("sec_up1", 0, 1, 1, 1, SSEC, 6'd0, 6'd1, 2'd0);
        step("sec_up2", 0, 1, 1, 1, SSEC, 6'd0, 6'd2, 2'd0);
        step("sec_up3", 0, 1, 1, 1, SSEC, 6'd0, 6'd3, 2'd0);
        // Minutes wrap down, then up wins when both buttons are low.
        step("min_dn_wrap", 1, 0, 1, 1, SMIN, 6'd59, 6'd3, 2'd0);
        step("min_both_up", 0, 0, 1, 1, SMIN, 6'd0, 6'd3, 2'd0);
        step("sec_dn", 1, 0, 1, 1, SSEC, 6'd0, 6'd2, 2'd0);
        step("other_mode", 0, 1, 1, 1, OFF, 6'd0, 6'd2, 2'd0);

        // Run 00:02 to expiry. Alarm is held for 10 ticks, and set modes are ignored.
        step("start_run", 1, 1, 0, 1, OFF, 6'd0, 6'd2, 2'd1);
        step("run_01", 1, 1, 1, 1, OFF, 6'd0, 6'd1, 2'd1);
        step("run_expire", 1, 1, 1, 1, OFF, 6'd0, 6'd0, 2'd3);
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("alarm_hold_%0d", i), 0, 1, 1, 1, SSEC,
                 6'd0, 6'd0, 2'd3);
        end
        step("alarm_timeout", 1, 1, 1, 1, OFF, 6'd0, RELOAD_A, 2'd0);

        // Clear, preset 01:00, then check borrow and pause/resume.
        step("clr_idle", 1, 1, 1, 0, OFF, 6'd0, 6'd0, 2'd0);
        step("min_up", 0, 1, 1, 1, SMIN, 6'd1, 6'd0, 2'd0);
        step("start_run2", 1, 1, 0, 1, OFF, 6'd1, 6'd0, 2'd1);
        step("borrow", 1, 1, 1, 1, OFF, 6'd0, 6'd59, 2'd1);
        step("pause", 1, 1, 0, 1, OFF, 6'd0, 6'd59, 2'd2);
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("pause_hold_%0d", i), 1, 1, 1, 1, OFF,
                 6'd0, 6'd59, 2'd2);
        end
        step("resume", 1, 1, 0, 1, OFF, 6'd0, 6'd59, 2'd1);
        step("run_58", 1, 1, 1, 1, OFF, 6'd0, 6'd58, 2'd1);
        step("pause2", 1, 1, 0, 1, OFF, 6'd0, 6'd58, 2'd2);
        step("pause_set", 1, 0, 1, 1, SSEC, 6'd0, 6'd57, 2'd2);
        step("resume2", 1, 1, 0, 1, OFF, 6'd0, 6'd57, 2'd1);
        for (int i = 1; i <= 27; i++) begin
            step($sformatf("run_ignore_set_%0d", i), 0, 1, 1, 1, SSEC,
                 6'd0, 6'(57 - i), 2'd1);
        end
        step("clr_run", 1, 1, 1, 0, OFF, 6'd0, 6'd0, 2'd0);
        step("start_zero", 1, 1, 0, 1, OFF, 6'd0, 6'd0, 2'd0);
        step("release", 1, 1, 1, 1, OFF, 6'd0, 6'd0, 2'd0);

        // Asynchronous reset in the middle of ALARM.
        step("set_01", 0, 1, 1, 1, SSEC, 6'd0, 6'd1, 2'd0);
        step("start_run3", 1, 1, 0, 1, OFF, 6'd0, 6'd1, 2'd1);
        step("expire3", 1, 1, 1, 1, OFF, 6'd0, 6'd0, 2'd3);
        step("alarm3", 1, 1, 1, 1, OFF, 6'd0, 6'd0, 2'd3);
        @(posedge clk_1Hz);
        #3;
        push_exp("async_rst_alarm", 6'd0, 6'd0, 2'd0);
        rst_n = 1'b0;
        @(negedge clk_1Hz);
        #2;
        rst_n = 1'b1;
        step("post_rst", 1, 1, 1, 1, OFF, 6'd0, 6'd0, 2'd0);

        // Preset 00:03, run to expiry, then acknowledge with btn_start.
        step("set_c1", 0, 1, 1, 1, SSEC, 6'd0, 6'd1, 2'd0);
        step("set_c2", 0, 1, 1, 1, SSEC, 6'd0, 6'd2, 2'd0);
        step("set_c3", 0, 1, 1, 1, SSEC, 6'd0, 6'd3, 2'd0);
        step("start_c", 1, 1, 0, 1, OFF, 6'd0, 6'd3, 2'd1);
        step("run_c2", 1, 1, 1, 1, OFF, 6'd0, 6'd2, 2'd1);
        step("run_c1", 1, 1, 1, 1, OFF, 6'd0, 6'd1, 2'd1);
        step("expire_c", 1, 1, 1, 1, OFF, 6'd0, 6'd0, 2'd3);
        step("ack", 1, 1, 0, 1, OFF, 6'd0, RELOAD_C, 2'd0);
        step("ack_release", 1, 1, 1, 1, OFF, 6'd0, RELOAD_C, 2'd0);

        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk_1Hz);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0",
                     exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting mm:ss timer for the clock's timer function; counts in the opposite direction to the time-of-day second/minute counters.
- Value is preset with the same active-low up/down buttons and mode bus the time-of-day counters use. Run/pause via a start button.
- On expiry, asserts alarm for a bounded number of seconds and drives the display/buzzer logic.
- Decrements once per clk_1Hz edge.

Parameters:
- SET_SEC_MODE, 3'b101, mode value that selects seconds-field adjust.
- SET_MIN_MODE, 3'b110, mode value that selects minutes-field adjust.
- MAX_MIN, 59, largest settable minute value (1..63).
- ALARM_SECS, 10, number of clk_1Hz cycles alarm stays high if not acknowledged (1..63).

Ports:
- clk_1Hz  input  1  1 Hz system tick clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_up  input  1  active-low, level-sampled each edge; increments selected field.
- btn_down  input  1  active-low, level-sampled each edge; decrements selected field.
- btn_start  input  1  active-low; falling edge toggles run/pause.
- btn_clr  input  1  active-low, level; clears timer.
- mode  input  3  global mode bus.
- min  output  6  remaining minutes, 0..MAX_MIN.
- sec  output  6  remaining seconds, 0..59.
- running  output  1  high in RUN.
- alarm  output  1  high in ALARM.
- state  output  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.

Behaviour:
- Reset (async, rst_n low):
  - min=0, sec=0, state=IDLE, running=0, alarm=0.
  - Alarm counter = 0.
  - Start-edge register btn_start_q = 1.
- Start edge: start_ev = btn_start_q & ~btn_start. btn_start_q <= btn_start every edge.
- Priority per edge: btn_clr low > start_ev > set/decrement.
- btn_clr low, any state: min=0, sec=0, go to IDLE, alarm=0.
- IDLE:
  - If mode==SET_SEC_MODE or SET_MIN_MODE, adjust field (see set rules).
  - start_ev with {min,sec}!=0 -> RUN.
  - start_ev with 00:00 -> stay IDLE.
- RUN:
  - Each edge, decrement: if sec>0 then sec-1; else min-1 and sec=59.
  - If the new value is 00:00 -> ALARM on the same edge; alarm rises with the display reaching 00:00.
  - start_ev -> PAUSE, value held, no decrement on that edge.
  - Set modes ignored.
- PAUSE:
  - Value held; set rules apply.
  - start_ev: {min,sec}!=0 -> RUN; 00:00 -> IDLE.
- ALARM:
  - Value held at 00:00; alarm counter increments each edge.
  - Exit to IDLE when counter reaches ALARM_SECS-1, or on start_ev (acknowledge). Counter cleared on exit.
  - Set modes ignored.
- Set rules (IDLE/PAUSE only), btn_up has priority when both low:
  - SET_SEC_MODE: up 59->0 wrap, down 0->59 wrap. No carry/borrow into min.
  - SET_MIN_MODE: up MAX_MIN->0 wrap, down 0->MAX_MIN wrap.
  - Held button repeats once per edge.
- Other mode values: no adjust; buttons ignored.
- Outputs are registered. running = (state==RUN), alarm = (state==ALARM), both registered alongside state.
- Reset mid-RUN or mid-ALARM: immediate return to reset values; no alarm glitch after release.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- With the macro defined:
  - A 12-bit preset register (reset 0) captures {min,sec} on every IDLE->RUN transition.
  - On ALARM exit (timeout or acknowledge), min/sec load the preset and state goes to IDLE.
  - btn_clr zeros both the value and the preset.
- Without the macro: no preset register; ALARM exit leaves 00:00.

Test Plan:
- Reset, then IDLE, SET_SEC_MODE, btn_up low 3 edges -> sec=3, min=0, state=0.
- SET_MIN_MODE, btn_down low 1 edge from min=0 -> min=MAX_MIN=59. Both buttons low 1 edge -> min=0 (up wins).
- Preset 00:02, start falling edge -> running=1. Next edge 00:01. Next edge 00:00 with alarm=1, state=3. After 10 edges total in ALARM -> state=0, alarm=0.
- Preset 01:00, run 1 edge -> 00:59. start edge -> PAUSE, value holds 00:59 for 5 edges. start edge -> RUN. Next edge 00:58.
- During RUN at 00:30, btn_clr low -> 00:00, IDLE. Async rst_n low mid-ALARM -> all outputs 0 immediately.
- With COUNTDOWN_AUTO_RELOAD_EN: preset 00:03, run to expiry, start edge acknowledge -> IDLE showing 00:03, alarm=0.
